// File: rtl/mu0_mem_reader.sv
// rtl/mu0_mem_reader.sv - MU0 bus initiator that streams a halted CPU's memory block and sums it
module mu0_mem_reader #(
    parameter int RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        STP_flag,
    input  logic [11:0] base,
    input  logic [11:0] count,
    output logic [11:0] addr,
    output logic        MEMrq,
    output logic        RnW,
    input  logic [15:0] data,
    output logic        bus_own,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT - 1);

    state_t        state;
    logic [11:0]   remaining;
    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 12'd0;
            MEMrq     <= 1'b0;
            RnW       <= 1'b0;
            bus_own   <= 1'b0;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= 16'd0;
            err       <= 1'b0;
            remaining <= 12'd0;
            wait_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Losing the halt releases the bus at once and wins over any handshake.
            if ((state == REQ || state == HOLD) && !STP_flag) begin
                state     <= IDLE;
                err       <= 1'b1;
                MEMrq     <= 1'b0;
                RnW       <= 1'b0;
                bus_own   <= 1'b0;
                busy      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (!STP_flag) begin
                                err <= 1'b1;
                            end else begin
                                sum <= 16'd0;
                                if (count == 12'd0) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state     <= REQ;
                                    addr      <= base;
                                    remaining <= count;
                                    wait_cnt  <= '0;
                                    MEMrq     <= 1'b1;
                                    RnW       <= 1'b1;
                                    bus_own   <= 1'b1;
                                    busy      <= 1'b1;
                                end
                            end
                        end
                    end
                    REQ: begin
                        if (wait_cnt == WAIT_LAST) begin
                            out_data  <= data;
                            sum       <= sum + data;
                            out_valid <= 1'b1;
                            MEMrq     <= 1'b0;
                            RnW       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (remaining == 12'd1) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                bus_own <= 1'b0;
                                busy    <= 1'b0;
                            end else begin
                                addr      <= addr + 12'd1;
                                remaining <= remaining - 12'd1;
                                wait_cnt  <= '0;
                                MEMrq     <= 1'b1;
                                RnW       <= 1'b1;
                                state     <= REQ;
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mu0_mem_reader.sv
// tb/tb_mu0_mem_reader.sv - randomized self-checking bench for mu0_mem_reader
module tb_mu0_mem_reader;

    localparam int RD_WAIT = 1;
    localparam int P = RD_WAIT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        STP_flag = 1'b1;
    logic [11:0] base = 12'd0;
    logic [11:0] count = 12'd0;
    logic [11:0] addr;
    logic        MEMrq;
    logic        RnW;
    logic [15:0] data;
    logic        bus_own;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        err;

    logic [15:0] mem [0:4095];
    int errors = 0;
    int checks = 0;

    assign data = mem[addr];

    always #5 clk = ~clk;

    mu0_mem_reader #(.RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .start(start), .STP_flag(STP_flag),
        .base(base), .count(count), .addr(addr), .MEMrq(MEMrq), .RnW(RnW),
        .data(data), .bus_own(bus_own), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .sum(sum), .err(err)
    );

    task automatic do_start(input logic [11:0] b, input logic [11:0] n);
        @(negedge clk);
        base  = b;
        count = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        logic [50:0] outs;
        rst = 1'b1;
        @(negedge clk);
        outs = {addr, MEMrq, RnW, bus_own, out_data, out_valid, busy, done, sum, err};
        checks++;
        if (outs !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        rst = 1'b0;
    endtask

    // Cycle-exact schedule with out_ready held high: word w occupies j in [w*P, w*P+P).
    task automatic test_timed(input logic [11:0] b, input int n);
        logic [15:0] exp_sum;
        logic [11:0] a;
        logic        in_req;
        int          w;
        exp_sum = 16'd0;
        for (int i = 0; i < n; i++) exp_sum = exp_sum + mem[12'(int'(b) + i)];
        out_ready = 1'b1;
        do_start(b, 12'(n));
        for (int j = 0; j <= n * P + 1; j++) begin
            @(negedge clk);
            w = j / P;
            a = 12'(int'(b) + w);
            in_req = (j % P) < RD_WAIT;
            if (j < n * P) begin
                checks++;
                if ({busy, bus_own, MEMrq, RnW, out_valid, done} !== {1'b1, 1'b1, in_req, in_req, !in_req, 1'b0}) begin
                    errors++;
                    $display("FAIL timed_ctrl j=%0d got=%b exp=%b", j,
                             {busy, bus_own, MEMrq, RnW, out_valid, done}, {1'b1, 1'b1, in_req, in_req, !in_req, 1'b0});
                end
                checks++;
                if (addr !== a) begin
                    errors++;
                    $display("FAIL timed_addr j=%0d got=%h exp=%h", j, addr, a);
                end
                if (!in_req) begin
                    checks++;
                    if (out_data !== mem[a]) begin
                        errors++;
                        $display("FAIL timed_data j=%0d got=%h exp=%h", j, out_data, mem[a]);
                    end
                end
            end else if (j == n * P) begin
                checks++;
                if ({done, busy, bus_own, MEMrq, out_valid} !== 5'b10000) begin
                    errors++;
                    $display("FAIL timed_done j=%0d got=%b exp=10000", j, {done, busy, bus_own, MEMrq, out_valid});
                end
            end else begin
                checks++;
                if ({done, busy, bus_own} !== 3'b000) begin
                    errors++;
                    $display("FAIL timed_after_done got=%b exp=000", {done, busy, bus_own});
                end
            end
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL timed_sum got=%h exp=%h", sum, exp_sum);
        end
    endtask

    // mode 0: always ready, 1: stall three cycles on the second word, 2: random ready and stray starts
    task automatic run_block(input logic [11:0] b, input int n, input int mode);
        logic [15:0] exp_q[$];
        logic [15:0] got_q[$];
        logic [11:0] a_q[$];
        logic [15:0] exp_sum;
        logic [15:0] prev_data;
        logic [11:0] prev_addr;
        logic        prev_valid, prev_acc, prev_mrq, seen_done;
        int          cycles, stalls;
        exp_sum = 16'd0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[12'(int'(b) + i)]);
            exp_sum = exp_sum + mem[12'(int'(b) + i)];
        end
        out_ready = 1'b1;
        do_start(b, 12'(n));
        cycles = 0; stalls = 0; seen_done = 1'b0;
        prev_valid = 1'b0; prev_acc = 1'b1; prev_mrq = 1'b0;
        prev_data = 16'd0; prev_addr = 12'd0;
        while (!seen_done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            checks++;
            if (MEMrq && !RnW) begin
                errors++;
                $display("FAIL rnw_low_with_memrq addr=%h", addr);
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL stray_err got=%b exp=0", err);
            end
            if (MEMrq && !prev_mrq) a_q.push_back(addr);
            if (out_valid && prev_valid && !prev_acc) begin
                checks++;
                if ({out_data, addr, MEMrq} !== {prev_data, prev_addr, 1'b0}) begin
                    errors++;
                    $display("FAIL stall_hold got=%h/%h/%b exp=%h/%h/0", out_data, addr, MEMrq, prev_data, prev_addr);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                start = 1'b0;
                out_ready = 1'b1;
            end else begin
                case (mode)
                    1: begin
                        if (out_valid && got_q.size() == 1 && stalls < 3) begin
                            out_ready = 1'b0;
                            stalls++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    2: begin
                        out_ready = 1'($urandom_range(0, 1));
                        start = 1'($urandom_range(0, 1));
                    end
                    default: out_ready = 1'b1;
                endcase
            end
            prev_acc = out_valid && out_ready;
            if (prev_acc) got_q.push_back(out_data);
            prev_valid = out_valid;
            prev_data = out_data;
            prev_addr = addr;
            prev_mrq = MEMrq;
        end
        start = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL block_timeout base=%h n=%0d got=no_done exp=done", b, n);
        end
        if (mode == 0) begin
            checks++;
            if (cycles - 1 != n * P) begin
                errors++;
                $display("FAIL block_latency got=%0d exp=%0d", cycles - 1, n * P);
            end
        end
        if (mode == 1 && n >= 2) begin
            checks++;
            if (stalls != 3) begin
                errors++;
                $display("FAIL stall_count got=%0d exp=3", stalls);
            end
        end
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL block_words base=%h n=%0d got=%p exp=%p", b, n, got_q, exp_q);
        end
        checks++;
        if (a_q.size() != n) begin
            errors++;
            $display("FAIL block_addr_count got=%0d exp=%0d", a_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (a_q[i] !== 12'(int'(b) + i)) begin
                    errors++;
                    $display("FAIL block_addr i=%0d got=%h exp=%h", i, a_q[i], 12'(int'(b) + i));
                end
            end
        end
        checks++;
        if (sum !== exp_sum) begin
            errors++;
            $display("FAIL block_sum got=%h exp=%h", sum, exp_sum);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, bus_own, MEMrq} !== 4'b0000) begin
            errors++;
            $display("FAIL block_idle got=%b exp=0000", {done, busy, bus_own, MEMrq});
        end
    endtask

    task automatic test_refused();
        logic [15:0] old_sum;
        old_sum = sum;
        STP_flag = 1'b0;
        do_start(12'h010, 12'd4);
        @(negedge clk);
        checks++;
        if ({err, busy, MEMrq, bus_own, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, old_sum}) begin
            errors++;
            $display("FAIL refused_start got=%b%b%b%b/%h exp=1000/%h", err, busy, MEMrq, bus_own, sum, old_sum);
        end
        @(negedge clk);
        checks++;
        if ({err, MEMrq} !== 2'b00) begin
            errors++;
            $display("FAIL refused_err_width got=%b exp=00", {err, MEMrq});
        end
        STP_flag = 1'b1;
    endtask

    task automatic test_zero_count();
        logic saw_mrq;
        saw_mrq = 1'b0;
        do_start(12'h123, 12'd0);
        @(negedge clk);
        saw_mrq = MEMrq;
        checks++;
        if ({done, sum, busy} !== {1'b1, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL zero_count got=%b/%h/%b exp=1/0000/0", done, sum, busy);
        end
        @(negedge clk);
        saw_mrq = saw_mrq | MEMrq;
        checks++;
        if ({done, saw_mrq, err} !== 3'b000) begin
            errors++;
            $display("FAIL zero_count_after got=%b exp=000", {done, saw_mrq, err});
        end
    endtask

    task automatic test_abort(input int n);
        int t;
        out_ready = 1'b1;
        do_start(12'h010, 12'(n));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_data == 16'd2) && t < 40);
        checks++;
        if (t >= 40) begin
            errors++;
            $display("FAIL abort_wait_word2 got=timeout exp=word2_valid");
        end
        STP_flag = 1'b0;
        @(negedge clk);
        checks++;
        if ({err, bus_own, MEMrq, out_valid, done, busy, sum} !== {6'b100000, 16'd3}) begin
            errors++;
            $display("FAIL abort_n%0d got=%b/%h exp=100000/0003", n,
                     {err, bus_own, MEMrq, out_valid, done, busy}, sum);
        end
        @(negedge clk);
        checks++;
        if ({err, done, bus_own} !== 3'b000) begin
            errors++;
            $display("FAIL abort_after_n%0d got=%b exp=000", n, {err, done, bus_own});
        end
        STP_flag = 1'b1;
    endtask

    task automatic test_reset_mid_req();
        logic [50:0] outs;
        do_start(12'h010, 12'd4);
        @(negedge clk);
        checks++;
        if (MEMrq !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_precondition got=%b exp=1", MEMrq);
        end
        #2 rst = 1'b1;
        #1;
        outs = {addr, MEMrq, RnW, bus_own, out_data, out_valid, busy, done, sum, err};
        checks++;
        if (outs !== 51'd0) begin
            errors++;
            $display("FAIL rst_mid_req got=%h exp=0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 3);
        mem[12'h010] = 16'd1;
        mem[12'h011] = 16'd2;
        mem[12'h012] = 16'd3;
        mem[12'h013] = 16'd4;
        mem[12'hFFE] = 16'hFFFF;
        mem[12'hFFF] = 16'h0002;
        mem[12'h000] = 16'h0005;

        test_reset();
        test_timed(12'h010, 4);
        run_block(12'h010, 4, 1);
        run_block(12'hFFE, 3, 0);
        test_refused();
        test_zero_count();
        test_abort(4);
        test_abort(2);
        for (int k = 0; k < 5; k++) begin
            logic [11:0] rb;
            int          rn;
            rb = 12'($urandom_range(0, 4095));
            rn = $urandom_range(1, 8);
            for (int i = 0; i < rn; i++) mem[12'(int'(rb) + i)] = 16'($urandom);
            // Keep the fixed scenario data intact for later tasks.
            mem[12'h010] = 16'd1; mem[12'h011] = 16'd2;
            mem[12'h012] = 16'd3; mem[12'h013] = 16'd4;
            run_block(rb, rn, 2);
        end
        test_reset_mid_req();
        test_timed(12'h7F0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
